// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared defaults and load-FSM encoding for the pixel framebuffer
package fb_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_HEIGHT = 32;
    localparam int DEF_CW     = 8;
    localparam int DEF_PIXELS = DEF_WIDTH * DEF_HEIGHT;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_R    = 3'd1,
        ST_LOAD_G    = 3'd2,
        ST_LOAD_B    = 3'd3,
        ST_WAIT_SWAP = 3'd4
    } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port RAM holding both banks, registered read port
module fb_ram #(
    parameter int AW = 11,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register resets; the array keeps its contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pixel_stream_framebuffer.sv
// rtl/pixel_stream_framebuffer.sv - double-buffered RGB framebuffer fed by a byte stream
module pixel_stream_framebuffer
    import fb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int CW     = DEF_CW,
    localparam int XW    = $clog2(WIDTH),
    localparam int YW    = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] in_data,
    input  logic          in_sof,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          frame_end,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic [CW-1:0] rd_r,
    output logic [CW-1:0] rd_g,
    output logic [CW-1:0] rd_b,
    output logic          front_sel,
    output logic          swap_done,
    output logic          err_desync
);

    localparam int AW = XW + YW;
    localparam int DW = 3 * CW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

    fb_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] g_q, g_d;
    logic          front_q, front_d;
    logic          swap_q, swap_d;
    logic          err_q, err_d;

    logic          accept;
    logic          ram_we;
    logic [DW-1:0] rd_data;

    assign in_ready = (state_q != ST_WAIT_SWAP);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        r_d     = r_q;
        g_d     = g_q;
        front_d = front_q;
        swap_d  = 1'b0;
        err_d   = err_q;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        r_d     = in_data;
                        addr_d  = '0;
                        state_d = ST_LOAD_G;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_R, ST_LOAD_G, ST_LOAD_B: begin
                if (accept) begin
                    if (in_sof) begin
                        // Start of frame mid-load: abandon the partial frame and restart at pixel 0.
                        r_d     = in_data;
                        addr_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_LOAD_G;
                    end else if (state_q == ST_LOAD_R) begin
                        r_d     = in_data;
                        state_d = ST_LOAD_G;
                    end else if (state_q == ST_LOAD_G) begin
                        g_d     = in_data;
                        state_d = ST_LOAD_B;
                    end else begin
                        ram_we = 1'b1;
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = ST_WAIT_SWAP;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_LOAD_R;
                        end
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (frame_end) begin
                    front_d = ~front_q;
                    swap_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            front_q <= 1'b0;
            swap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            r_q     <= r_d;
            g_q     <= g_d;
            front_q <= front_d;
            swap_q  <= swap_d;
            err_q   <= err_d;
        end
    end

    // Bank is the address MSB: writes go to the back bank, reads to the front bank.
    fb_ram #(
        .AW (AW + 1),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr ({~front_q, addr_q}),
        .wdata ({r_q, g_q, in_data}),
        .raddr ({front_q, rd_y, rd_x}),
        .rdata (rd_data)
    );

    assign rd_r       = rd_data[DW-1:2*CW];
    assign rd_g       = rd_data[2*CW-1:CW];
    assign rd_b       = rd_data[CW-1:0];
    assign front_sel  = front_q;
    assign swap_done  = swap_q;
    assign err_desync = err_q;

endmodule

// File: tb/tb_pixel_stream_framebuffer.sv
// tb/tb_pixel_stream_framebuffer.sv - directed self-checking bench for pixel_stream_framebuffer
module tb_pixel_stream_framebuffer;

    logic       clk;
    logic       resetn;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_valid;
    logic       in_ready;
    logic       frame_end;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic [7:0] rd_r;
    logic [7:0] rd_g;
    logic [7:0] rd_b;
    logic       front_sel;
    logic       swap_done;
    logic       err_desync;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_stream_framebuffer dut (
        .clk        (clk),
        .reset      (resetn),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frame_end  (frame_end),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_r       (rd_r),
        .rd_g       (rd_g),
        .rd_b       (rd_b),
        .front_sel  (front_sel),
        .swap_done  (swap_done),
        .err_desync (err_desync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input logic [7:0] k, input int n);
        logic [7:0] lo;
        lo = n[7:0];
        return {lo ^ k, ~lo ^ k, 8'h5A ^ k ^ {6'b0, n[9:8]}};
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic fe);
        int t;
        @(negedge clk);
        in_data   = d;
        in_sof    = sof;
        in_valid  = 1'b1;
        frame_end = fe;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            frame_end = 1'b0;
            t++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] k, input int count, input int fe_a, input int fe_b);
        logic [23:0] p;
        logic [7:0]  d;
        for (int i = 0; i < count; i++) begin
            p = pix(k, i / 3);
            d = (i % 3 == 0) ? p[23:16] : ((i % 3 == 1) ? p[15:8] : p[7:0]);
            send_byte(d, i == 0, (i == fe_a) || (i == fe_b));
        end
    endtask

    task automatic send_frame(input logic [7:0] k, input int fe_a, input int fe_b);
        send_bytes(k, 3072, fe_a, fe_b);
        go_idle();
    endtask

    // Pulses frame_end for one edge; returns sampled swap_done/front_sel of the swap cycle.
    task automatic pulse_frame_end(output logic sd, output logic fs);
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        sd = swap_done;
        fs = front_sel;
    endtask

    task automatic read_px(input int x, input int y, output logic [23:0] px);
        @(negedge clk);
        rd_x = 5'(x);
        rd_y = 5'(y);
        @(negedge clk);
        px = {rd_r, rd_g, rd_b};
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        frame_end = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [23:0] px;
        logic        sd;
        logic        fs;
        int          acc;

        resetn    = 1'b0;
        in_data   = 8'h00;
        in_sof    = 1'b0;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        rd_x      = 5'd0;
        rd_y      = 5'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        check("rst_rd", 32'({rd_r, rd_g, rd_b}), 32'h0);
        check("rst_front", 32'(front_sel), 32'd0);
        check("rst_swap", 32'(swap_done), 32'd0);
        check("rst_err", 32'(err_desync), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Frame A into bank 1, then swap.
        send_frame(8'h00, -1, -1);
        check("a_wait_ready", 32'(in_ready), 32'd0);
        check("a_err", 32'(err_desync), 32'd0);
        pulse_frame_end(sd, fs);
        check("a_swap_done", 32'(sd), 32'd1);
        check("a_front", 32'(fs), 32'd1);
        @(negedge clk);
        check("a_swap_pulse_len", 32'(swap_done), 32'd0);
        read_px(3, 2, px);
        check("a_px_3_2", 32'(px), 32'h43BC5A);

        // frame_end during load and on final-B cycle must be ignored.
        send_frame(8'h21, 600, 3071);
        check("b_front_hold", 32'(front_sel), 32'd1);
        check("b_wait_ready", 32'(in_ready), 32'd0);
        read_px(3, 2, px);
        check("b_old_front", 32'(px), 32'h43BC5A);
        pulse_frame_end(sd, fs);
        check("b_swap_done", 32'(sd), 32'd1);
        check("b_front", 32'(fs), 32'd0);
        read_px(5, 7, px);
        check("b_px_5_7", 32'(px), 32'(pix(8'h21, 229)));

        // Non-sof bytes in IDLE are dropped and flag desync.
        do_reset();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        go_idle();
        check("drop_err", 32'(err_desync), 32'd1);
        check("drop_ready", 32'(in_ready), 32'd1);
        send_frame(8'h42, -1, -1);
        check("c_wait_ready", 32'(in_ready), 32'd0);
        pulse_frame_end(sd, fs);
        check("c_front", 32'(fs), 32'd1);
        read_px(0, 0, px);
        check("c_px_0", 32'(px), 32'(pix(8'h42, 0)));
        read_px(31, 31, px);
        check("c_px_1023", 32'(px), 32'(pix(8'h42, 1023)));

        // sof after 100 bytes restarts the frame.
        do_reset();
        send_bytes(8'h63, 100, -1, -1);
        check("p_err_before", 32'(err_desync), 32'd0);
        send_frame(8'h84, -1, -1);
        check("d_err", 32'(err_desync), 32'd1);
        check("d_wait_ready", 32'(in_ready), 32'd0);
        pulse_frame_end(sd, fs);
        check("d_front", 32'(fs), 32'd1);
        read_px(0, 0, px);
        check("d_px_0", 32'(px), 32'(pix(8'h84, 0)));
        read_px(1, 1, px);
        check("d_px_33", 32'(px), 32'(pix(8'h84, 33)));
        read_px(31, 31, px);
        check("d_px_1023", 32'(px), 32'(pix(8'h84, 1023)));

        // Holding valid in WAIT_SWAP accepts nothing.
        send_frame(8'hA5, -1, -1);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 8'h99;
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        check("hold_accepted", 32'(acc), 32'd0);
        go_idle();
        pulse_frame_end(sd, fs);
        check("e_front", 32'(fs), 32'd0);
        read_px(10, 20, px);
        check("e_px_650", 32'(px), 32'(pix(8'hA5, 650)));

        // First byte after a swap without sof is dropped; the next sof frame is aligned.
        send_byte(8'h77, 1'b0, 1'b0);
        send_frame(8'hC6, -1, -1);
        pulse_frame_end(sd, fs);
        check("g_front", 32'(fs), 32'd1);
        read_px(0, 0, px);
        check("g_px_0", 32'(px), 32'(pix(8'hC6, 0)));
        read_px(20, 15, px);
        check("g_px_500", 32'(px), 32'(pix(8'hC6, 500)));

        send_frame(8'hE7, -1, -1);
        pulse_frame_end(sd, fs);
        check("h_front", 32'(fs), 32'd0);
        read_px(7, 9, px);
        check("h_px_295", 32'(px), 32'(pix(8'hE7, 295)));

        // Reset mid-load at byte 1500.
        send_bytes(8'h18, 1500, -1, -1);
        #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_rd", 32'({rd_r, rd_g, rd_b}), 32'h0);
        check("mid_rst_front", 32'(front_sel), 32'd0);
        check("mid_rst_swap", 32'(swap_done), 32'd0);
        check("mid_rst_err", 32'(err_desync), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        read_px(31, 31, px);
        check("f_old_px_1023", 32'(px), 32'(pix(8'hE7, 1023)));
        read_px(0, 0, px);
        check("f_old_px_0", 32'(px), 32'(pix(8'hE7, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_framebuffer.md
Name: pixel_stream_framebuffer

Overview:
Double-buffered 32x32 RGB888 framebuffer sitting directly upstream of the HUB75 scan driver, replacing the static image ROM lookup. The write side takes a byte stream (R,G,B per pixel, raster order) with valid/ready handshake, from the host link. The read side serves pixels to the scan driver by (x,y) with 1-cycle latency. Buffers swap only at the scan driver's frame boundary, so there is no tearing.

Parameters:
WIDTH, 32, pixels per row (power of two)
HEIGHT, 32, rows (power of two)
CW, 8, bits per colour channel
Derived, not overridable: XW=log2(WIDTH), YW=log2(HEIGHT), AW=XW+YW

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  8  stream byte
in_sof  in  1  qualifies in_data as first byte (R of pixel 0) of a frame
in_valid  in  1  byte present
in_ready  out  1  byte accepted when in_valid&&in_ready
frame_end  in  1  one-clk pulse from scan driver after last row of a refresh
rd_x  in  XW  read column
rd_y  in  YW  read row
rd_r  out  CW  red, registered
rd_g  out  CW  green, registered
rd_b  out  CW  blue, registered
front_sel  out  1  bank currently displayed
swap_done  out  1  one-clk pulse on the cycle front_sel toggles
err_desync  out  1  sticky: non-sof byte dropped in IDLE, or sof restarted a partial frame

Behaviour:
- Reset (async assert, sync-release use): state=IDLE, front_sel=0, pixel address=0, R/G holding regs=0, rd_r/g/b=0, swap_done=0, err_desync=0. RAM contents not cleared. Reset mid-load discards the partial frame.
- States: IDLE, LOAD_R, LOAD_G, LOAD_B, WAIT_SWAP.
- in_ready=1 in IDLE/LOAD_*; 0 in WAIT_SWAP.
- IDLE: accepted byte with in_sof -> store R, addr=0, go LOAD_G. Accepted byte without in_sof -> dropped, err_desync<=1.
- LOAD_R: accepted byte -> store R, go LOAD_G (in_sof here: treated as restart, addr=0, err_desync<=1, byte stored as R).
- LOAD_G: store G, go LOAD_B. LOAD_B: write {R,G,in_data} (3*CW bits) to back bank (~front_sel) at addr={y,x}=addr. If addr==WIDTH*HEIGHT-1 -> addr wraps to 0, go WAIT_SWAP; else addr+1, go LOAD_R.
- in_sof during LOAD_G/LOAD_B: restart as above (byte stored as R of pixel 0, go LOAD_G, err_desync<=1); no RAM write that cycle.
- WAIT_SWAP: on frame_end -> front_sel<=~front_sel, swap_done=1 for that one cycle, go IDLE. frame_end in any other state ignored (no swap, no latch).
- Final B byte and frame_end same cycle: no swap; swap waits for the next frame_end.
- Read: rd_* <= RAM[front_sel][{rd_y,rd_x}] each clk, unconditional, latency 1. A read issued in the swap cycle returns old-bank data; the following cycle returns new-bank data.
- Write and read never hit the same bank at the same time (write=back, read=front), so no collision rule is needed.
- Throughput: 1 byte/clk while in_ready.

Decomposition:
- Package fb_pkg: WIDTH/HEIGHT/CW defaults, state encoding constants, PIXELS=WIDTH*HEIGHT.
- Sub-module fb_ram: simple dual-port RAM, depth 2*PIXELS, width 3*CW, 1 sync write port, 1 sync read port (registered output, no reset on array). Bank select is the address MSB.

Test Plan:
- Reset, stream 3072 bytes with pixel n = (n[7:0], ~n[7:0], 0x5A), sof on byte 0 -> WAIT_SWAP, in_ready=0. frame_end pulse -> swap_done=1, front_sel=1. Read (x=3,y=2) -> next cycle rd_r=0x43, rd_g=0xBC, rd_b=0x5A.
- frame_end pulses during load and on the final-B cycle -> front_sel unchanged. Next frame_end -> swap.
- Bytes 0x11,0x22 without sof after reset -> dropped, err_desync=1, state IDLE. Then a valid frame still loads correctly.
- sof after 100 bytes of a frame -> addr restarts, err_desync=1. A full 3072-byte frame after the restart displays correctly with no stale pixels shifted.
- Hold in_valid=1 in WAIT_SWAP for 50 clks -> no bytes accepted. After swap, the first accepted byte must carry sof.
- Assert reset mid-load (byte 1500) -> all outputs at reset values immediately, front_sel=0. The old front image is still readable after release.
